// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin one-hot grant arbiter.
//
// Contents:
//   rr_state_e    - arbiter FSM state (idle / holding a grant)
//   idx_width()   - index width for n requesters, never less than 1
//   idx_wrap_inc()- increment an index, wrapping from n-1 back to 0
package rr_arb_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StHold = 1'b1
    } rr_state_e;

    // $clog2(1) is 0, which cannot size a port; clamp to 1.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Explicit wrap so non-power-of-2 counts never produce an index >= n.
    function automatic int unsigned idx_wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Circular priority picker (purely combinational).
//
// Returns the first set bit of req_i at or above ptr_i, wrapping from N-1 to 0.
// Requests at or above the pointer are searched first; if none exist the full
// request vector is searched, which yields the wrapped-around winner.
//
// Ports:
//   req_i   [N-1:0]     request vector
//   ptr_i   [IDX_W-1:0] priority pointer (lowest index with top priority)
//   idx_o   [IDX_W-1:0] winning index (0 when nothing is requested)
//   found_o             at least one request present
module rr_prio_pick import rr_arb_pkg::*; #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    logic [N-1:0]     masked;
    logic [IDX_W-1:0] idx_hi;
    logic [IDX_W-1:0] idx_lo;
    logic             found_hi;

    always_comb begin
        masked   = '0;
        idx_hi   = '0;
        idx_lo   = '0;
        found_hi = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            masked[i] = req_i[i] && (IDX_W'(i) >= ptr_i);
        end
        // Scan downward so the last hit taken is the lowest set index.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (masked[i]) begin
                idx_hi   = IDX_W'(i);
                found_hi = 1'b1;
            end
            if (req_i[i]) begin
                idx_lo = IDX_W'(i);
            end
        end
        found_o = |req_i;
        idx_o   = found_hi ? idx_hi : idx_lo;
    end

endmodule

// File: rtl/rr_onehot_grant.sv
// Round-robin arbiter with registered one-hot grant and valid/ready handshake.
//
// A grant, once issued, is held (sticky) until the consumer accepts it. On
// accept the priority pointer moves just past the accepted index and a new
// winner is loaded in the same cycle, so grants can stream one per cycle.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   req_i        [N-1:0] request vector
//   gnt_ready_i  consumer accepts the current grant
//   gnt_o        [N-1:0] registered grant, zero or one-hot
//   gnt_valid_o  gnt_o holds a live grant
//   gnt_idx_o    [IDX_W-1:0] binary index of the set bit in gnt_o
//   gnt_err_o    sticky grant integrity error
//
// Build option RR_ONEHOT_GRANT_CHECK_EN: when defined, an integrity checker
// watches the grant registers and sets gnt_err_o; otherwise gnt_err_o is 0.
module rr_onehot_grant import rr_arb_pkg::*; #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = idx_width(N)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N-1:0]     req_i,
    input  logic             gnt_ready_i,
    output logic [N-1:0]     gnt_o,
    output logic             gnt_valid_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_err_o
);

    rr_state_e        state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic             accept;
    logic [IDX_W-1:0] ptr_next;
    logic [IDX_W-1:0] pick_ptr;
    logic [IDX_W-1:0] win_idx;
    logic             win_found;

    assign accept   = (state_q == StHold) && gnt_ready_i;
    assign ptr_next = IDX_W'(idx_wrap_inc(32'(gnt_idx_q), N));
    // On accept the next winner must already honour the advanced pointer.
    assign pick_ptr = accept ? ptr_next : ptr_q;

    rr_prio_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (req_i),
        .ptr_i   (pick_ptr),
        .idx_o   (win_idx),
        .found_o (win_found)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        ptr_d     = ptr_q;
        // Load a new grant from idle, or right after an accept.
        if ((state_q == StIdle) || accept) begin
            if (accept) begin
                ptr_d = ptr_next;
            end
            if (win_found) begin
                gnt_d          = '0;
                gnt_d[win_idx] = 1'b1;
                gnt_idx_d      = win_idx;
                state_d        = StHold;
            end else begin
                gnt_d     = '0;
                gnt_idx_d = '0;
                state_d   = StIdle;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            ptr_q     <= ptr_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_valid_o = (state_q == StHold);
    assign gnt_idx_o   = gnt_idx_q;

`ifdef RR_ONEHOT_GRANT_CHECK_EN
    // H/Z/F reduction: Zero bits set, one Hot bit, or Fault (two or more).
    localparam logic [1:0] HzfZ = 2'd0;
    localparam logic [1:0] HzfH = 2'd1;
    localparam logic [1:0] HzfF = 2'd2;

    function automatic logic [1:0] hzf_join(input logic [1:0] a, input logic [1:0] b);
        if ((a == HzfF) || (b == HzfF)) return HzfF;
        if ((a == HzfH) && (b == HzfH)) return HzfF;
        if ((a == HzfH) || (b == HzfH)) return HzfH;
        return HzfZ;
    endfunction

    logic [1:0] hzf;
    logic       idx_bad;
    logic       err_now;
    logic       err_q;

    always_comb begin
        hzf = HzfZ;
        for (int i = 0; i < int'(N); i++) begin
            hzf = hzf_join(hzf, gnt_q[i] ? HzfH : HzfZ);
        end
        idx_bad = (32'(gnt_idx_q) >= N) || !gnt_q[gnt_idx_q];
        if (gnt_valid_o) begin
            err_now = (hzf != HzfH) || idx_bad;
        end else begin
            err_now = (hzf != HzfZ) || (gnt_idx_q != '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (err_now) begin
            err_q <= 1'b1;
        end
    end

    assign gnt_err_o = err_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!err_now) else $error("rr_onehot_grant: grant integrity violation");
        end
    end
`endif
`else
    assign gnt_err_o = 1'b0;
`endif

endmodule
